panel_scan_ctrl: RTL and testbench

Sequences the 8-port analog RAM interface that carries the front-panel controls (range x3, frequency x2, waveform x3). Steps the port address, waits a settling interval, then samples and hysteresis-filters each 8-bit value. Holds a clean shadow copy of all 8 controls and emits a one-cycle update strobe whenever a control genuinely changes. Sits between the analog RAM and oscBank / switch-position decode, replacing free-running address counting with a controlled, glitch-free scan.

---
 rtl/panel_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_panel_scan_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/panel_scan_ctrl.sv
// Scans the 8 analog RAM ports, settles, samples and hysteresis-filters each value into a shadow array.
// Dwell is SETTLE_CYCLES+3 clocks per port; scan_en is honoured only at port boundaries.
module panel_scan_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int HYST          = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scan_en,
  output logic [2:0] addr,
  input  logic [7:0] data,
  input  logic [2:0] rd_sel,
  output logic [7:0] rd_data,
  output logic       upd_valid,
  output logic [2:0] upd_port,
  output logic [7:0] upd_value,
  output logic       scan_done,
  output logic       all_valid
);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, FILTER, NEXT} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  addr_q, addr_d;
  logic [7:0]  samp_q, samp_d;
  logic [7:0]  seen_q, seen_d;
  logic [7:0]  shadow_q [8];
  logic        shadow_we;
  logic        upd_valid_q, upd_valid_d;
  logic [2:0]  upd_port_q, upd_port_d;
  logic [7:0]  upd_value_q, upd_value_d;
  logic        scan_done_q, scan_done_d;
  logic        all_valid_q, all_valid_d;

  logic [7:0]  cur_shadow;
  logic [8:0]  diff;
  logic        rail_move;
  logic        accept;

  // Rail values bypass hysteresis so full-scale settings are always reachable.
  assign cur_shadow = shadow_q[addr_q];
  assign diff       = (samp_q >= cur_shadow) ? ({1'b0, samp_q} - {1'b0, cur_shadow})
                                             : ({1'b0, cur_shadow} - {1'b0, samp_q});
  assign rail_move  = ((samp_q == 8'h00) || (samp_q == 8'hFF)) && (samp_q != cur_shadow);
  assign accept     = !seen_q[addr_q] || (diff >= 9'(HYST)) || rail_move;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scan_en) state_d = SETTLE;
      SETTLE:  if (cnt_q == 4'd0) state_d = SAMPLE;
      SAMPLE:  state_d = FILTER;
      FILTER:  state_d = NEXT;
      NEXT:    state_d = scan_en ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    samp_d      = samp_q;
    seen_d      = seen_q;
    shadow_we   = 1'b0;
    upd_valid_d = 1'b0;
    upd_port_d  = upd_port_q;
    upd_value_d = upd_value_q;
    scan_done_d = 1'b0;
    all_valid_d = all_valid_q;
    case (state_q)
      IDLE:   if (scan_en) cnt_d = SETTLE_LOAD;
      SETTLE: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      SAMPLE: samp_d = data;
      FILTER: begin
        if (accept) begin
          shadow_we      = 1'b1;
          seen_d[addr_q] = 1'b1;
          upd_valid_d    = 1'b1;
          upd_port_d     = addr_q;
          upd_value_d    = samp_q;
        end
      end
      NEXT: begin
        addr_d = addr_q + 3'd1;
        if (addr_q == 3'd7) begin
          scan_done_d = 1'b1;
          if (&seen_q) all_valid_d = 1'b1;
        end
        if (scan_en) cnt_d = SETTLE_LOAD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      samp_q      <= '0;
      seen_q      <= '0;
      upd_valid_q <= 1'b0;
      upd_port_q  <= '0;
      upd_value_q <= '0;
      scan_done_q <= 1'b0;
      all_valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      samp_q      <= samp_d;
      seen_q      <= seen_d;
      upd_valid_q <= upd_valid_d;
      upd_port_q  <= upd_port_d;
      upd_value_q <= upd_value_d;
      scan_done_q <= scan_done_d;
      all_valid_q <= all_valid_d;
      if (shadow_we) shadow_q[addr_q] <= samp_q;
    end
  end

  assign addr      = addr_q;
  assign rd_data   = shadow_q[rd_sel];
  assign upd_valid = upd_valid_q;
  assign upd_port  = upd_port_q;
  assign upd_value = upd_value_q;
  assign scan_done = scan_done_q;
  assign all_valid = all_valid_q;

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// Randomized bench for panel_scan_ctrl: a per-visit model of the accept rule predicts every strobe and shadow read.
module tb_panel_scan_ctrl;
  localparam int SC = 4;
  localparam int HY = 2;

  logic       clk = 1'b0;
  logic       reset_n, scan_en;
  logic [2:0] addr, rd_sel, upd_port;
  logic [7:0] data, rd_data, upd_value;
  logic       upd_valid, scan_done, all_valid;
  logic [7:0] ram [8];

  assign data = ram[addr];

  panel_scan_ctrl #(.SETTLE_CYCLES(SC), .HYST(HY)) dut (
    .clk(clk), .reset_n(reset_n), .scan_en(scan_en), .addr(addr), .data(data),
    .rd_sel(rd_sel), .rd_data(rd_data), .upd_valid(upd_valid), .upd_port(upd_port),
    .upd_value(upd_value), .scan_done(scan_done), .all_valid(all_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sh_m [8];
  bit         seen_m [8];
  bit         av_m, done_m;
  int         p_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit acc_m(input bit seen, input logic [7:0] o, input logic [7:0] n);
    int d;
    d = (n > o) ? int'(n) - int'(o) : int'(o) - int'(n);
    return !seen || (d >= HY) || (((n == 8'h00) || (n == 8'hFF)) && (n != o));
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 8; i++) begin
      sh_m[i]   = 8'h00;
      seen_m[i] = 1'b0;
    end
    av_m = 0; done_m = 0; p_m = 0;
  endtask

  task automatic perturb(input int p);
    case ($urandom_range(0, 5))
      0: ;
      1: ram[p] = ram[p] + 8'd1;
      2: ram[p] = ram[p] - 8'd1;
      3: ram[p] = ram[p] + 8'($urandom_range(2, 4));
      4: ram[p] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      default: ram[p] = 8'($urandom_range(0, 255));
    endcase
  endtask

  // Entered at the first SETTLE cycle of port p_m; leaves at the NEXT cycle.
  task automatic do_visit(input bit stop, input bit abort, output bit aborted);
    logic [7:0] v, old;
    bit a;
    int p;
    p = p_m;
    aborted = 0;
    chk("addr", addr, p);
    chk("scan_done_start", scan_done, done_m);
    chk("all_valid", all_valid, av_m);
    chk("upd_valid_start", upd_valid, 0);
    if (stop) scan_en = 0;
    v   = ram[p];
    old = sh_m[p];
    a   = acc_m(seen_m[p], old, v);
    rd_sel = 3'($urandom_range(0, 7));
    #1 chk("rd_data_any", rd_data, sh_m[rd_sel]);
    for (int off = 1; off <= 6; off++) begin
      if (off == 4) rd_sel = p[2:0];
      @(negedge clk);
      if (abort && off == 5) begin
        reset_n = 0;
        scan_en = 0;
        aborted = 1;
        return;
      end
      chk("upd_valid", upd_valid, (off == 6) && a);
      chk("scan_done", scan_done, 0);
      if (off == 5) chk("rd_old", rd_data, old);
      if (off == 6) begin
        chk("rd_new", rd_data, a ? v : old);
        if (a) begin
          chk("upd_port", upd_port, p);
          chk("upd_value", upd_value, v);
        end
      end
    end
    if (a) begin
      sh_m[p]   = v;
      seen_m[p] = 1'b1;
    end
    done_m = (p == 7);
    if (p == 7) begin
      bit all;
      all = 1;
      for (int i = 0; i < 8; i++) all = all & seen_m[i];
      if (all) av_m = 1;
    end
    p_m = (p + 1) % 8;
  endtask

  task automatic sweep(input int stop_port, input int abort_port, input bit rnd);
    int p;
    bit ab;
    for (int k = 0; k < 8; k++) begin
      p = p_m;
      if (rnd) perturb(p);
      do_visit(p == stop_port, p == abort_port, ab);
      if (ab) begin
        @(negedge clk);
        reset_model();
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_all_valid", all_valid, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_addr", addr, 0);
        for (int i = 0; i < 8; i++) begin
          rd_sel = 3'(i);
          #1 chk("rst_shadow", rd_data, 0);
        end
        reset_n = 1;
        @(negedge clk);
        scan_en = 1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
      if (p == stop_port) begin
        repeat (10) begin
          chk("idle_addr", addr, p_m);
          chk("idle_upd", upd_valid, 0);
          chk("idle_done", scan_done, done_m);
          done_m = 0;
          @(negedge clk);
        end
        scan_en = 1;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    reset_n = 0;
    scan_en = 0;
    rd_sel  = 0;
    for (int i = 0; i < 8; i++) ram[i] = 8'h55;
    repeat (3) @(negedge clk);
    chk("reset_addr", addr, 0);
    chk("reset_upd_valid", upd_valid, 0);
    chk("reset_upd_port", upd_port, 0);
    chk("reset_upd_value", upd_value, 0);
    chk("reset_scan_done", scan_done, 0);
    chk("reset_all_valid", all_valid, 0);
    reset_n = 1;
    reset_model();
    @(negedge clk);
    chk("idle_hold_addr", addr, 0);
    for (int i = 0; i < 8; i++) ram[i] = 8'h10 + 8'(i);
    scan_en = 1;
    @(negedge clk);
    sweep(-1, -1, 0);
    ram[3] = 8'h14; sweep(-1, -1, 0);
    ram[3] = 8'h16; sweep(-1, -1, 0);
    ram[5] = 8'hFE; sweep(-1, -1, 0);
    ram[5] = 8'hFF; sweep(-1, -1, 0);
    sweep(4, -1, 0);
    repeat (20) sweep(-1, -1, 1);
    sweep($urandom_range(0, 7), -1, 1);
    sweep(-1, 2, 1);
    sweep(-1, -1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
